// File: rtl/ppm_pkg.sv
// ----------------------------------------------------------------------------
// ppm_pkg
// Shared definitions for the PPM transmit path frame scheduler:
//   - phase codes driven on the transmitter 'order' input
//   - scheduler state enumeration
//   - default phase / slot lengths
//   - helpers: state-to-order decode and a byte-wide CRC-8 update
// ----------------------------------------------------------------------------
package ppm_pkg;

    // Phase codes seen by the PPM symbol transmitter.
    localparam logic [1:0] ORDER_IDLE = 2'b00;
    localparam logic [1:0] ORDER_SOF  = 2'b01;
    localparam logic [1:0] ORDER_DATA = 2'b10;
    localparam logic [1:0] ORDER_EOF  = 2'b11;

    // Default timing, in clock cycles.
    localparam int unsigned DEFAULT_SLOT_CYCLES = 128;
    localparam int unsigned DEFAULT_SOF_CYCLES  = 128;
    localparam int unsigned DEFAULT_EOF_CYCLES  = 64;

    // StCrc is only reachable when the CRC feature is compiled in.
    typedef enum logic [2:0] {
        StCollect,
        StSof,
        StData,
        StCrc,
        StEof,
        StGap
    } sched_state_e;

    // Phase code presented to the transmitter while in a given state.
    // The CRC byte is sent as ordinary data symbols.
    function automatic logic [1:0] order_of(input sched_state_e st);
        logic [1:0] code;
        unique case (st)
            StSof:   code = ORDER_SOF;
            StData:  code = ORDER_DATA;
            StCrc:   code = ORDER_DATA;
            StEof:   code = ORDER_EOF;
            default: code = ORDER_IDLE;
        endcase
        return code;
    endfunction

    // CRC-8, polynomial 0x07, MSB first, no reflection, no final XOR.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/ppm_frame_buffer.sv
// ----------------------------------------------------------------------------
// ppm_frame_buffer
// DEPTH x 8 frame staging RAM: one synchronous write port, one synchronous
// read port. Addressing is owned by the scheduler.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous active-high reset (read data register only)
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   write byte
//   rd_en    in   read strobe; rd_data updates on the following edge
//   rd_addr  in   read address
//   rd_data  out  registered read byte, holds between reads, 0 after reset
// ----------------------------------------------------------------------------
module ppm_frame_buffer
    import ppm_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_data_q;

    // Storage is not reset; contents are only meaningful once written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read register doubles as the transmitter's byte register, so it
    // holds its value until the next explicit read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= 8'h00;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ppm_frame_scheduler.sv
// ----------------------------------------------------------------------------
// ppm_frame_scheduler
// Collects up to DEPTH bytes from a valid/ready stream into a frame buffer,
// then plays the frame out to the PPM symbol transmitter:
//   SOF -> 4 two-bit symbols per byte (LSB pair first) -> EOF -> idle gap.
//
// Optional feature: define PPM_SCHED_CRC_EN to append a CRC-8 (poly 0x07,
// init 0x00, MSB first) of the payload as an extra four-symbol byte.
//
// Ports:
//   clk         in   clock
//   rst         in   asynchronous active-high reset; aborts any frame
//   s_valid     in   input byte valid
//   s_data      in   input byte
//   s_last      in   final byte of frame
//   s_ready     out  byte can be accepted (COLLECT with buffer space only)
//   order       out  phase code 00 idle, 01 SOF, 10 data, 11 EOF
//   clk_count   out  cycle index within phase or symbol slot
//   bit_count   out  symbol index within the current byte
//   tx_byte     out  byte being transmitted, stable across its four slots
//   busy        out  high in every state except COLLECT
//   frame_done  out  one-cycle pulse on the last EOF cycle
// ----------------------------------------------------------------------------
module ppm_frame_scheduler
    import ppm_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned SLOT_CYCLES = DEFAULT_SLOT_CYCLES,
    parameter int unsigned SOF_CYCLES  = DEFAULT_SOF_CYCLES,
    parameter int unsigned EOF_CYCLES  = DEFAULT_EOF_CYCLES,
    parameter int unsigned GAP_CYCLES  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic [1:0] order,
    output logic [9:0] clk_count,
    output logic [1:0] bit_count,
    output logic [7:0] tx_byte,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] FILL_MAX  = CNT_W'(DEPTH);
    localparam logic [9:0]       SLOT_LAST = 10'(SLOT_CYCLES - 1);
    localparam logic [9:0]       SOF_LAST  = 10'(SOF_CYCLES - 1);
    localparam logic [9:0]       EOF_LAST  = 10'(EOF_CYCLES - 1);
    localparam logic [9:0]       GAP_LAST  = 10'(GAP_CYCLES - 1);

    sched_state_e     state_q, state_d;
    logic [9:0]       clk_count_q, clk_count_d;
    logic [1:0]       bit_count_q, bit_count_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]       order_q, order_d;
    logic             s_ready_q, s_ready_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;

    logic             accept;
    logic             slot_end;
    logic             last_byte;
    logic             rd_en;
    logic [PTR_W-1:0] rd_addr;
    logic [7:0]       rd_data;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        clk_count_d = clk_count_q + 10'd1;
        bit_count_d = bit_count_q;
        fill_d      = fill_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_en       = 1'b0;
        rd_addr     = rd_ptr_q;
        accept      = 1'b0;
        slot_end    = (clk_count_q == SLOT_LAST);
        last_byte   = (CNT_W'(rd_ptr_q) == (fill_q - CNT_W'(1)));

        unique case (state_q)
            StCollect: begin
                clk_count_d = 10'd0;
                // s_ready_q already encodes COLLECT with space left.
                accept = s_valid && s_ready_q;
                if (accept) begin
                    fill_d   = fill_q + CNT_W'(1);
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (s_last || (fill_d == FILL_MAX)) begin
                        state_d = StSof;
                    end
                end
            end

            StSof: begin
                if (clk_count_q == SOF_LAST) begin
                    state_d     = StData;
                    clk_count_d = 10'd0;
                    bit_count_d = 2'd0;
                    rd_ptr_d    = '0;
                    // Fetch the first byte now so it is on tx_byte in the
                    // first DATA cycle.
                    rd_en       = 1'b1;
                    rd_addr     = '0;
                end
            end

            StData: begin
                if (slot_end) begin
                    clk_count_d = 10'd0;
                    bit_count_d = bit_count_q + 2'd1;
                    if (bit_count_q == 2'd3) begin
                        if (last_byte) begin
`ifdef PPM_SCHED_CRC_EN
                            state_d = StCrc;
`else
                            state_d = StEof;
`endif
                        end else begin
                            rd_ptr_d = rd_ptr_q + PTR_W'(1);
                            rd_en    = 1'b1;
                            rd_addr  = rd_ptr_d;
                        end
                    end
                end
            end

            StCrc: begin
                if (slot_end) begin
                    clk_count_d = 10'd0;
                    bit_count_d = bit_count_q + 2'd1;
                    if (bit_count_q == 2'd3) begin
                        state_d = StEof;
                    end
                end
            end

            StEof: begin
                if (clk_count_q == EOF_LAST) begin
                    state_d     = StGap;
                    clk_count_d = 10'd0;
                end
            end

            StGap: begin
                if (clk_count_q == GAP_LAST) begin
                    state_d     = StCollect;
                    clk_count_d = 10'd0;
                    fill_d      = '0;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                end
            end

            default: begin
                state_d     = StCollect;
                clk_count_d = 10'd0;
            end
        endcase

        // Outputs are registered from next-state values so they line up
        // with the state they describe.
        order_d      = order_of(state_d);
        s_ready_d    = (state_d == StCollect) && (fill_d < FILL_MAX);
        busy_d       = (state_d != StCollect);
        frame_done_d = (state_d == StEof) && (clk_count_d == EOF_LAST);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StCollect;
            clk_count_q  <= 10'd0;
            bit_count_q  <= 2'd0;
            fill_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            order_q      <= ORDER_IDLE;
            s_ready_q    <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_count_q  <= clk_count_d;
            bit_count_q  <= bit_count_d;
            fill_q       <= fill_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            order_q      <= order_d;
            s_ready_q    <= s_ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame buffer
    // ------------------------------------------------------------------
    ppm_frame_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_frame_buffer (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_addr (wr_ptr_q),
        .wr_data (s_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // ------------------------------------------------------------------
    // Optional CRC byte
    // ------------------------------------------------------------------
`ifdef PPM_SCHED_CRC_EN
    logic [7:0] crc_q, crc_d;
    logic       crc_sel_q, crc_sel_d;

    always_comb begin
        crc_d = crc_q;
        if (accept) begin
            crc_d = crc8_update(crc_q, s_data);
        end else if (state_q == StGap) begin
            crc_d = 8'h00;
        end
        crc_sel_d = (state_d == StCrc);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q     <= 8'h00;
            crc_sel_q <= 1'b0;
        end else begin
            crc_q     <= crc_d;
            crc_sel_q <= crc_sel_d;
        end
    end

    // Both mux inputs are flops and crc_q cannot change while selected.
    assign tx_byte = crc_sel_q ? crc_q : rd_data;
`else
    assign tx_byte = rd_data;
`endif

    assign s_ready    = s_ready_q;
    assign order      = order_q;
    assign clk_count  = clk_count_q;
    assign bit_count  = bit_count_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
